// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
interface mux_rr_arbiter_if;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       BUSY;

  // Requester side: drives requests and observes the grant.
  modport master (
    output REQ,
    input  GNT,
    input  SEL,
    input  BUSY
  );

  // Arbiter side: samples requests and owns the grant outputs.
  modport slave (
    input  REQ,
    output GNT,
    output SEL,
    output BUSY
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux among four requesters.
// Produces a registered one-hot grant and the encoded select for the mux S
// input. A burst limit keeps one owner from starving pending requesters.
module mux_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  mux_rr_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] othersReq;
  logic [1:0] idleWinner;
  logic [1:0] handWinner;

  // First candidate with its bit set, scanning last+1, last+2, last+3, last+4.
  function automatic logic [1:0] rrPick(input logic [3:0] cand, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign othersReq  = bus.REQ & ~(4'b0001 << last_q);
  assign idleWinner = rrPick(bus.REQ, last_q);
  assign handWinner = rrPick(othersReq, last_q);

  // Next-state arbitration: idle pick, release handoff, burst expiry, or hold.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (|bus.REQ) begin
        gnt_d   = 4'b0001 << idleWinner;
        sel_d   = idleWinner;
        last_d  = idleWinner;
        cnt_d   = 8'd1;
        busy_d  = 1'b1;
        state_d = GRANT;
      end
    end else begin
      if (!bus.REQ[last_q] || (cnt_q == MaxBurst && |othersReq)) begin
        if (|othersReq) begin
          gnt_d  = 4'b0001 << handWinner;
          sel_d  = handWinner;
          last_d = handWinner;
          cnt_d  = 8'd1;
        end else begin
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end else if (cnt_q < MaxBurst) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State and output registers; LAST resets to 3 so the first pick starts at 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.SEL  = sel_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: two instances (burst limit 4 and 1) share
// the clock, reset and request pattern and are compared against a
// cycle-level model of the round-robin rules.
module tb_mux_rr_arbiter;

  logic CLK;
  logic RST_N;

  mux_rr_arbiter_if ifA ();
  mux_rr_arbiter_if ifB ();

  mux_rr_arbiter #(.MAX_BURST(4)) dutA (.CLK(CLK), .RST_N(RST_N), .bus(ifA.slave));
  mux_rr_arbiter #(.MAX_BURST(1)) dutB (.CLK(CLK), .RST_N(RST_N), .bus(ifB.slave));

  typedef struct packed {
    int owner;
    int last;
    int cnt;
    int sel;
  } mstate_t;

  mstate_t mA, mB;
  int checks = 0;
  int passed = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic mstate_t modelReset();
    mstate_t s;
    s.owner = -1;
    s.last  = 3;
    s.cnt   = 0;
    s.sel   = 0;
    return s;
  endfunction

  function automatic int rrWinner(input logic [3:0] cand, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (cand[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic mstate_t modelNext(input mstate_t s, input logic [3:0] req, input int maxBurst);
    mstate_t n;
    logic [3:0] others;
    int w;
    n = s;
    w = -1;
    if (s.owner < 0) begin
      if (req != 4'b0000) w = rrWinner(req, s.last);
    end else begin
      others = req;
      others[s.owner] = 1'b0;
      if (!req[s.owner] || (s.cnt >= maxBurst && others != 4'b0000)) begin
        if (others != 4'b0000) w = rrWinner(others, s.last);
        else n.owner = -1;
      end else begin
        n.cnt = (s.cnt + 1 > maxBurst) ? maxBurst : s.cnt + 1;
      end
    end
    if (w >= 0) begin
      n.owner = w;
      n.last  = w;
      n.sel   = w;
      n.cnt   = 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] expGnt(input mstate_t s);
    return (s.owner < 0) ? 4'b0000 : (4'b0001 << s.owner);
  endfunction

  // Drive requests, let one rising edge pass, sample 1 time unit after it.
  task automatic stepCycle(input logic [3:0] req);
    ifA.REQ = req;
    ifB.REQ = req;
    @(posedge CLK);
    #1;
    mA = modelNext(mA, req, 4);
    mB = modelNext(mB, req, 1);
  endtask

  task automatic doReset();
    ifA.REQ = 4'b0000;
    ifB.REQ = 4'b0000;
    @(negedge CLK);
    RST_N = 1'b0;
    #2;
    mA = modelReset();
    mB = modelReset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (ifA.GNT !== 4'b0000 || ifA.SEL !== 2'd0 || ifA.BUSY !== 1'b0) begin
      $display("[TB] FAIL reset_outputs: got gnt=%b sel=%0d busy=%b want gnt=0000 sel=0 busy=0",
               ifA.GNT, ifA.SEL, ifA.BUSY);
    end else passed++;
    stepCycle(4'b0000);
    checks++;
    if (ifA.GNT !== 4'b0000 || ifA.BUSY !== 1'b0) begin
      $display("[TB] FAIL reset_idle: got gnt=%b busy=%b want 0000/0", ifA.GNT, ifA.BUSY);
    end else passed++;
  endtask

  task automatic test_single_request();
    doReset();
    stepCycle(4'b0100);
    checks++;
    if (ifA.GNT !== 4'b0100 || ifA.SEL !== 2'd2 || ifA.BUSY !== 1'b1) begin
      $display("[TB] FAIL single_grant: got gnt=%b sel=%0d busy=%b want 0100/2/1",
               ifA.GNT, ifA.SEL, ifA.BUSY);
    end else passed++;
    stepCycle(4'b0000);
    checks++;
    if (ifA.GNT !== 4'b0000 || ifA.SEL !== 2'd2 || ifA.BUSY !== 1'b0) begin
      $display("[TB] FAIL single_release: got gnt=%b sel=%0d busy=%b want 0000/2/0",
               ifA.GNT, ifA.SEL, ifA.BUSY);
    end else passed++;
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    doReset();
    for (int c = 0; c < 20; c++) begin
      stepCycle(4'b1111);
      want = 4'b0001 << ((c / 4) % 4);
      checks++;
      if (ifA.GNT !== want || ifA.SEL !== 2'((c / 4) % 4)) begin
        $display("[TB] FAIL fairness cycle %0d: got gnt=%b sel=%0d want gnt=%b sel=%0d",
                 c, ifA.GNT, ifA.SEL, want, (c / 4) % 4);
      end else passed++;
    end
  endtask

  task automatic test_early_release();
    doReset();
    stepCycle(4'b1010);
    stepCycle(4'b1010);
    checks++;
    if (ifA.GNT !== 4'b0010) begin
      $display("[TB] FAIL early_owner1: got gnt=%b want 0010", ifA.GNT);
    end else passed++;
    stepCycle(4'b1000);
    checks++;
    if (ifA.GNT !== 4'b1000 || ifA.SEL !== 2'd3) begin
      $display("[TB] FAIL early_handoff: got gnt=%b sel=%0d want 1000/3", ifA.GNT, ifA.SEL);
    end else passed++;
    // Owner 3 started a fresh burst of 4, so it keeps the grant 3 more edges.
    for (int c = 0; c < 3; c++) begin
      stepCycle(4'b1010);
      checks++;
      if (ifA.GNT !== 4'b1000) begin
        $display("[TB] FAIL early_cnt_restart cycle %0d: got gnt=%b want 1000", c, ifA.GNT);
      end else passed++;
    end
    stepCycle(4'b1010);
    checks++;
    if (ifA.GNT !== 4'b0010 || ifA.SEL !== 2'd1) begin
      $display("[TB] FAIL early_burst_end: got gnt=%b sel=%0d want 0010/1", ifA.GNT, ifA.SEL);
    end else passed++;
  endtask

  task automatic test_saturation();
    int bad;
    doReset();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      stepCycle(4'b0001);
      if (ifA.GNT !== 4'b0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("[TB] FAIL saturation_hold: %0d of 10 cycles had gnt!=0001 (last gnt=%b)", bad, ifA.GNT);
    end else passed++;
    stepCycle(4'b0101);
    checks++;
    if (ifA.GNT !== 4'b0100 || ifA.SEL !== 2'd2) begin
      $display("[TB] FAIL saturation_contention: got gnt=%b sel=%0d want 0100/2", ifA.GNT, ifA.SEL);
    end else passed++;
  endtask

  task automatic test_max_burst_one();
    logic [3:0] want;
    doReset();
    for (int c = 0; c < 8; c++) begin
      stepCycle(4'b0101);
      want = (c % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (ifB.GNT !== want) begin
        $display("[TB] FAIL burst1_alternate cycle %0d: got gnt=%b want %b", c, ifB.GNT, want);
      end else passed++;
    end
  endtask

  task automatic test_async_reset();
    doReset();
    stepCycle(4'b0010);
    stepCycle(4'b0010);
    checks++;
    if (ifA.GNT !== 4'b0010) begin
      $display("[TB] FAIL async_setup: got gnt=%b want 0010", ifA.GNT);
    end else passed++;
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (ifA.GNT !== 4'b0000 || ifA.SEL !== 2'd0 || ifA.BUSY !== 1'b0) begin
      $display("[TB] FAIL async_clear: got gnt=%b sel=%0d busy=%b want 0000/0/0",
               ifA.GNT, ifA.SEL, ifA.BUSY);
    end else passed++;
    mA = modelReset();
    mB = modelReset();
    @(negedge CLK);
    RST_N = 1'b1;
    stepCycle(4'b1111);
    checks++;
    if (ifA.GNT !== 4'b0001 || ifA.SEL !== 2'd0) begin
      $display("[TB] FAIL async_first_grant: got gnt=%b sel=%0d want 0001/0", ifA.GNT, ifA.SEL);
    end else passed++;
  endtask

  task automatic test_random();
    logic [3:0] req;
    int badA, badB;
    doReset();
    req  = 4'b0000;
    badA = 0;
    badB = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      stepCycle(req);
      checks++;
      if (ifA.GNT !== expGnt(mA) || ifA.SEL !== 2'(mA.sel) || ifA.BUSY !== (mA.owner >= 0)) begin
        if (badA < 5)
          $display("[TB] FAIL random_burst4 cycle %0d req=%b: got gnt=%b sel=%0d busy=%b want gnt=%b sel=%0d busy=%b",
                   c, req, ifA.GNT, ifA.SEL, ifA.BUSY, expGnt(mA), mA.sel, mA.owner >= 0);
        badA++;
      end else passed++;
      checks++;
      if (ifB.GNT !== expGnt(mB) || ifB.SEL !== 2'(mB.sel) || ifB.BUSY !== (mB.owner >= 0)) begin
        if (badB < 5)
          $display("[TB] FAIL random_burst1 cycle %0d req=%b: got gnt=%b sel=%0d busy=%b want gnt=%b sel=%0d busy=%b",
                   c, req, ifB.GNT, ifB.SEL, ifB.BUSY, expGnt(mB), mB.sel, mB.owner >= 0);
        badB++;
      end else passed++;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    RST_N   = 1'b1;
    ifA.REQ = 4'b0000;
    ifB.REQ = 4'b0000;
    mA = modelReset();
    mB = modelReset();
    test_reset();
    test_single_request();
    test_fairness();
    test_early_release();
    test_saturation();
    test_max_burst_one();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
